ps2_scancode_rx: RTL and testbench

- Upstream stage of the PS/2 keyboard-to-LCD path.
- Receives 11-bit PS/2 device-to-host frames from the keyboard, validates start, odd parity and stop bits, and presents the 8-bit scan code.
- The code is presented as two held nibbles, oHEX1 and oHEX0, that drive the hex1/hex0 inputs of the LCD display driver, plus a one-cycle valid strobe.
- Receive-only. The block never drives the PS/2 lines.

---
 rtl/ps2_scancode_rx.sv | 171 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the PS/2 clock,
// checks start/odd-parity/stop and presents the scan code. Optional macro: PS2_BREAK_FILTER_EN.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [7:0] oSCAN_CODE,
    output logic       oVALID,
    output logic       oERR,
    output logic       oBUSY,
    output logic [3:0] oHEX1,
    output logic [3:0] oHEX0
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0]  filter_q, filter_d;
    logic                   filt_clk_q, filt_clk_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   stop_q, stop_d;
    logic [7:0]             code_q, code_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   fall;
    logic                   dat;
    logic                   good;
`ifdef PS2_BREAK_FILTER_EN
    logic                   brk_q, brk_d;
`endif

    // Filter register reflects the synchronised clock; a fall is the cycle the
    // filtered level is still 1 but the whole history has gone low.
    assign fall = filt_clk_q & ~(|filter_q);
    assign dat  = dat_sync_q[1];
    assign good = (^shift_q ^ parity_q) & stop_q;

    always_comb begin
        state_d    = state_q;
        filter_d   = {filter_q[FILTER_LEN-2:0], clk_sync_q[1]};
        filt_clk_d = filt_clk_q;
        bitcnt_d   = bitcnt_q;
        timer_d    = timer_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        stop_d     = stop_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        brk_d      = brk_q;
`endif
        if (~(|filter_q)) begin
            filt_clk_d = 1'b0;
        end else if (&filter_q) begin
            filt_clk_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall && !dat) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd0;
                    timer_d  = '0;
                end
            end
            RECV: begin
                if (fall) begin
                    timer_d = '0;
                    if (bitcnt_q < 4'd8) begin
                        shift_d  = {dat, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (bitcnt_q == 4'd8) begin
                        parity_d = dat;
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else begin
                        stop_d  = dat;
                        state_d = CHECK;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (good) begin
`ifdef PS2_BREAK_FILTER_EN
                    // Swallow the F0 prefix and the break code that follows it.
                    if (brk_q) begin
                        brk_d = 1'b0;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                    end
`else
                    code_d  = shift_q;
                    valid_d = 1'b1;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filter_q   <= '1;
            filt_clk_q <= 1'b1;
            bitcnt_q   <= '0;
            timer_q    <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            stop_q     <= 1'b0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[0], iPS2_CLK};
            dat_sync_q <= {dat_sync_q[0], iPS2_DAT};
            filter_q   <= filter_d;
            filt_clk_q <= filt_clk_d;
            bitcnt_q   <= bitcnt_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            stop_q     <= stop_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
`ifdef PS2_BREAK_FILTER_EN
            brk_q      <= brk_d;
`endif
        end
    end

    assign oSCAN_CODE = code_q;
    assign oHEX1      = code_q[7:4];
    assign oHEX0      = code_q[3:0];
    assign oVALID     = valid_q;
    assign oERR       = err_q;
    assign oBUSY      = busy_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed plus randomized PS/2 frames against a frame-level reference model
// (expected code, brk flag, pulse counts and latency).
module tb_ps2_scancode_rx;
    localparam int FL   = 8;
    localparam int TO   = 5000;
    localparam int HALF = 40;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iPS2_CLK = 1'b1;
    logic       iPS2_DAT = 1'b1;
    logic [7:0] oSCAN_CODE;
    logic       oVALID, oERR, oBUSY;
    logic [3:0] oHEX1, oHEX0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .iCLK(iCLK), .iRST(iRST), .iPS2_CLK(iPS2_CLK), .iPS2_DAT(iPS2_DAT),
        .oSCAN_CODE(oSCAN_CODE), .oVALID(oVALID), .oERR(oERR), .oBUSY(oBUSY),
        .oHEX1(oHEX1), .oHEX0(oHEX0)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0, err_cnt = 0, both_cnt = 0;
    int last_pulse_cyc = 0;
    int last_fall_cyc = 0;

    logic [7:0] exp_code = 8'h00;
    logic       brk = 1'b0;

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(negedge iCLK) begin
        if (oVALID) begin valid_cnt <= valid_cnt + 1; last_pulse_cyc <= cyc; end
        if (oERR)   begin err_cnt <= err_cnt + 1;     last_pulse_cyc <= cyc; end
        if (oVALID && oERR) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        iPS2_DAT = b;
        wait_cyc(HALF);
        iPS2_CLK = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        iPS2_CLK = 1'b1;
    endtask

    task automatic glitch();
        wait_cyc(HALF / 2);
        iPS2_CLK = 1'b0;
        wait_cyc(3);
        iPS2_CLK = 1'b1;
    endtask

    // Sends one frame, updates the model and checks everything observable.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic par_bad,
                             input logic stop_b, input int glitch_at);
        logic par;
        logic good;
        logic exp_v;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        par = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        par = par ^ par_bad;
        send_bit(1'b0);
        if (glitch_at == 0) glitch();
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (glitch_at == i + 1) glitch();
        end
        send_bit(par);
        send_bit(stop_b);
        wait_cyc(HALF);
        iPS2_DAT = 1'b1;

        good  = ((($countones(d) + int'(par)) % 2) == 1) && stop_b;
        exp_v = 1'b0;
        if (good) begin
`ifdef PS2_BREAK_FILTER_EN
            if (brk) brk = 1'b0;
            else if (d == 8'hF0) brk = 1'b1;
            else begin exp_code = d; exp_v = 1'b1; end
`else
            exp_code = d; exp_v = 1'b1;
`endif
        end
        check({tag, "_valid"}, valid_cnt - v0, {31'd0, exp_v});
        check({tag, "_err"},   err_cnt - e0,   {31'd0, ~good});
        check({tag, "_code"},  oSCAN_CODE, exp_code);
        check({tag, "_hex1"},  oHEX1, exp_code[7:4]);
        check({tag, "_hex0"},  oHEX0, exp_code[3:0]);
        check({tag, "_busy"},  oBUSY, 0);
        check({tag, "_both"},  both_cnt, 0);
        if (exp_v || !good)
            check({tag, "_lat"}, last_pulse_cyc - last_fall_cyc, FL + 4);
        $display("frame %s data=%02h par=%0b stop=%0b -> code=%02h valid=%0d err=%0d",
                 tag, d, par, stop_b, oSCAN_CODE, valid_cnt - v0, err_cnt - e0);
    endtask

    initial begin
        int v0, e0, t0, waited;
        logic [7:0] rd;

        wait_cyc(5);
        iRST = 1'b0;
        @(negedge iCLK);
        check("rst_code", oSCAN_CODE, 0);
        check("rst_valid", oVALID, 0);
        check("rst_err", oERR, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_hex", {oHEX1, oHEX0}, 0);
        wait_cyc(20);

        // Idle fall with data high must be ignored.
        e0 = err_cnt;
        send_bit(1'b1);
        wait_cyc(HALF);
        check("idle_fall_busy", oBUSY, 0);
        check("idle_fall_err", err_cnt - e0, 0);
        $display("idle fall with data=1 -> busy=%0b", oBUSY);

        run_frame("t1", 8'h1C, 1'b0, 1'b1, -1);
        run_frame("t2a", 8'h1C, 1'b1, 1'b1, -1);
        run_frame("t2b", 8'h32, 1'b0, 1'b0, -1);

        // Partial frame, then the clock stays high until the timeout fires.
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        iPS2_DAT = 1'b1;
        t0 = last_fall_cyc;
        waited = 0;
        while (err_cnt == e0 && waited < 2 * TO) begin
            wait_cyc(1);
            waited++;
        end
        wait_cyc(1);
        check("to_err", err_cnt - e0, 1);
        check("to_lat_win", ((last_pulse_cyc - t0) >= FL + 2 + TO) &&
                            ((last_pulse_cyc - t0) <= FL + 4 + TO), 1);
        check("to_busy", oBUSY, 0);
        check("to_valid", valid_cnt - v0, 0);
        $display("timeout err after %0d cycles from last clock drop", last_pulse_cyc - t0);
        wait_cyc(TO + TO / 5 - waited);
        run_frame("t3", 8'h32, 1'b0, 1'b1, -1);

        // Glitch while idle, then a frame with a mid-frame glitch.
        e0 = err_cnt;
        glitch();
        wait_cyc(HALF);
        check("glitch_idle_busy", oBUSY, 0);
        check("glitch_idle_err", err_cnt - e0, 0);
        $display("idle glitch -> busy=%0b", oBUSY);
        run_frame("t4", 8'hA5, 1'b0, 1'b1, 4);

        run_frame("t5a", 8'h1C, 1'b0, 1'b1, -1);
        run_frame("t5b", 8'hF0, 1'b0, 1'b1, -1);
        run_frame("t5c", 8'h1C, 1'b0, 1'b1, -1);

        // Reset after the fifth data bit discards the frame silently.
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        wait_cyc(5);
        iRST = 1'b1;
        wait_cyc(1);
        iRST = 1'b0;
        @(negedge iCLK);
        exp_code = 8'h00;
        brk = 1'b0;
        check("t6_code", oSCAN_CODE, 0);
        check("t6_busy", oBUSY, 0);
        check("t6_hex", {oHEX1, oHEX0}, 0);
        wait_cyc(HALF);
        check("t6_err", err_cnt - e0, 0);
        iPS2_DAT = 1'b1;
        $display("mid-frame reset -> code=%02h busy=%0b", oSCAN_CODE, oBUSY);
        wait_cyc(20);
        run_frame("t6", 8'h1C, 1'b0, 1'b1, -1);

        for (int n = 0; n < 14; n++) begin
            rd = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rd = 8'hF0;
            run_frame($sformatf("r%0d", n), rd, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0) ? 3 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
